// File: rtl/game_pkg.sv
// Shared definitions for the game's input path: debounce state encodings and defaults.
package game_pkg;

   localparam logic [1:0] DB_UP        = 2'd0;
   localparam logic [1:0] DB_CONF_DOWN = 2'd1;
   localparam logic [1:0] DB_DOWN      = 2'd2;
   localparam logic [1:0] DB_CONF_UP   = 2'd3;

   localparam int unsigned STABLE_SAMPLES_DEFAULT = 4;

   typedef enum logic [1:0] {
      StUp       = DB_UP,
      StConfDown = DB_CONF_DOWN,
      StDown     = DB_DOWN,
      StConfUp   = DB_CONF_UP
   } db_state_e;

endpackage

// File: rtl/debounce_cell.sv
// One button's confirm FSM: accepts a level change only after STABLE_SAMPLES equal samples,
// emitting a registered level plus one-cycle press/release pulses.
module debounce_cell
   import game_pkg::*;
#(
   parameter int unsigned STABLE_SAMPLES = STABLE_SAMPLES_DEFAULT
) (
   input  logic clk_in,
   input  logic rst_n,
   input  logic tick,
   input  logic btn_sync,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   localparam logic [3:0] STABLE_CNT = 4'(STABLE_SAMPLES);

   db_state_e  state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       level_q, level_d;
   logic       press_q, press_d;
   logic       release_q, release_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (tick) begin
         unique case (state_q)
            StUp: begin
               if (btn_sync) begin
                  state_d = StConfDown;
                  cnt_d   = 4'd1;
               end
            end
            StConfDown: begin
               if (!btn_sync) begin
                  state_d = StUp;
                  cnt_d   = 4'd0;
               end else if (cnt_q + 4'd1 == STABLE_CNT) begin
                  state_d = StDown;
                  cnt_d   = 4'd0;
                  press_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            StDown: begin
               if (!btn_sync) begin
                  state_d = StConfUp;
                  cnt_d   = 4'd1;
               end
            end
            StConfUp: begin
               if (btn_sync) begin
                  state_d = StDown;
                  cnt_d   = 4'd0;
               end else if (cnt_q + 4'd1 == STABLE_CNT) begin
                  state_d   = StUp;
                  cnt_d     = 4'd0;
                  release_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            default: begin
               state_d = StUp;
               cnt_d   = 4'd0;
            end
         endcase
      end
      // Level follows the accepted state, so it stays high while a release is being confirmed.
      level_d = (state_d == StDown) || (state_d == StConfUp);
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StUp;
         cnt_q     <= 4'd0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: recovers a sample tick from the display square wave, synchronizes the
// raw buttons and filters each one through its own debounce_cell.
module button_debounce
   import game_pkg::*;
#(
   parameter int unsigned NUM_BTN        = 5,
   parameter int unsigned STABLE_SAMPLES = STABLE_SAMPLES_DEFAULT
) (
   input  logic               clk_in,
   input  logic               rst_n,
   input  logic               clk_display,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release
);

   logic               disp_s1_q, disp_s2_q, disp_prev_q;
   logic               tick_q;
   logic [NUM_BTN-1:0] btn_s1_q, btn_sync;

   // clk_display is sampled as data; the registered edge gives a 3-cycle tick latency.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         disp_s1_q   <= 1'b0;
         disp_s2_q   <= 1'b0;
         disp_prev_q <= 1'b0;
         tick_q      <= 1'b0;
         btn_s1_q    <= '0;
         btn_sync    <= '0;
      end else begin
         disp_s1_q   <= clk_display;
         disp_s2_q   <= disp_s1_q;
         disp_prev_q <= disp_s2_q;
         tick_q      <= disp_s2_q & ~disp_prev_q;
         btn_s1_q    <= btn_raw;
         btn_sync    <= btn_s1_q;
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
      debounce_cell #(
         .STABLE_SAMPLES(STABLE_SAMPLES)
      ) u_cell (
         .clk_in     (clk_in),
         .rst_n      (rst_n),
         .tick       (tick_q),
         .btn_sync   (btn_sync[i]),
         .btn_level  (btn_level[i]),
         .btn_press  (btn_press[i]),
         .btn_release(btn_release[i])
      );
   end

endmodule
